// File: rtl/dccm_port_arb_if.sv
// -----------------------------------------------------------------------------
// dccm_port_arb_if
// Purpose : bundles the requester handshakes (LSU, DMA), the freeze control,
//           the read-return path and the DCCM memory pins that meet at the
//           DCCM port arbiter.
// Modports:
//   master - everything outside the arbiter (requesters and the DCCM macro):
//            drives freeze, requests and dccm_rd_data; observes grants,
//            rvalids, rd_data and the DCCM control/address/data pins.
//   slave  - the arbiter itself (mirror image of master).
// Parameters: AW = DCCM byte-address width, DW = DCCM data width incl. ECC.
// -----------------------------------------------------------------------------
interface dccm_port_arb_if #(
  parameter int AW = 16,
  parameter int DW = 39
);
  logic          freeze;

  logic          lsu_req;
  logic          lsu_wr;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_gnt;
  logic          lsu_rvalid;

  logic          dma_req;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;

  logic [DW-1:0] rd_data;

  logic          dccm_wren;
  logic          dccm_rden;
  logic [AW-1:0] dccm_wr_addr;
  logic [AW-1:0] dccm_rd_addr;
  logic [DW-1:0] dccm_wr_data;
  logic [DW-1:0] dccm_rd_data;

  modport master (
    output freeze,
    output lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid,
    input  rd_data,
    input  dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
    output dccm_rd_data
  );

  modport slave (
    input  freeze,
    input  lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid,
    output rd_data,
    output dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
    input  dccm_rd_data
  );
endinterface

// File: rtl/dccm_port_arb.sv
// -----------------------------------------------------------------------------
// dccm_port_arb
// Purpose : arbitrates the single DCCM read/write port between the LSU
//           (fixed priority) and the DMA (secondary). A saturating starvation
//           counter forces one DMA grant after DMA_MAX_STALL lost cycles.
//           Drives the DCCM pins and steers 1-cycle-latency read data back
//           to the requester that issued the read.
// Ports   :
//   clk  - core clock
//   rst  - synchronous reset, active-high
//   bus  - dccm_port_arb_if.slave: freeze, LSU/DMA req/wr/addr/wdata in,
//          gnt/rvalid out, rd_data out, DCCM wren/rden/addr/wr_data out,
//          dccm_rd_data in.
// Parameters: AW, DW (widths), DMA_MAX_STALL (1..255).
// -----------------------------------------------------------------------------
module dccm_port_arb #(
  parameter int AW            = 16,
  parameter int DW            = 39,
  parameter int DMA_MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst,
  dccm_port_arb_if.slave    bus
);

  localparam logic [7:0] MAX_CNT_C = 8'(DMA_MAX_STALL);

  typedef enum logic [0:0] {
    LSU_PRI   = 1'b0,
    DMA_FORCE = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    stall_cnt_r;
  logic [7:0]    stall_cnt_nxt_s;
  logic          lsu_rd_r;
  logic          dma_rd_r;

  logic          lsu_gnt_s;
  logic          dma_gnt_s;
  logic          sel_wr_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Grant selection; reset and freeze suppress every grant.
  always_comb begin
    lsu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    if (rst || bus.freeze) begin
      lsu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
    end else begin
      case (state_r)
        LSU_PRI: begin
          if (bus.lsu_req) begin
            lsu_gnt_s = 1'b1;
          end else begin
            dma_gnt_s = bus.dma_req;
          end
        end
        DMA_FORCE: begin
          if (bus.dma_req) begin
            dma_gnt_s = 1'b1;
          end else begin
            lsu_gnt_s = bus.lsu_req;
          end
        end
        default: begin
          lsu_gnt_s = bus.lsu_req;
          dma_gnt_s = bus.dma_req & ~bus.lsu_req;
        end
      endcase
    end
  end

  // Starvation counter and FSM next state; freeze holds both.
  always_comb begin
    stall_cnt_nxt_s = stall_cnt_r;
    state_nxt_s     = state_r;
    if (bus.freeze) begin
      stall_cnt_nxt_s = stall_cnt_r;
      state_nxt_s     = state_r;
    end else begin
      if (!bus.dma_req || dma_gnt_s) begin
        stall_cnt_nxt_s = 8'd0;
      end else if (stall_cnt_r >= MAX_CNT_C) begin
        stall_cnt_nxt_s = MAX_CNT_C;
      end else begin
        stall_cnt_nxt_s = stall_cnt_r + 8'd1;
      end

      case (state_r)
        LSU_PRI: begin
          if (stall_cnt_nxt_s == MAX_CNT_C) begin
            state_nxt_s = DMA_FORCE;
          end else begin
            state_nxt_s = LSU_PRI;
          end
        end
        DMA_FORCE: begin
          if (dma_gnt_s || !bus.dma_req) begin
            state_nxt_s = LSU_PRI;
          end else begin
            state_nxt_s = DMA_FORCE;
          end
        end
        default: begin
          state_nxt_s = LSU_PRI;
        end
      endcase
    end
  end

  // State, counter and read-ownership registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LSU_PRI;
      stall_cnt_r <= 8'd0;
      lsu_rd_r    <= 1'b0;
      dma_rd_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      lsu_rd_r    <= lsu_gnt_s & ~bus.lsu_wr;
      dma_rd_r    <= dma_gnt_s & ~bus.dma_wr;
    end
  end

  // Mux the granted requester onto the DCCM pins; zeros when idle.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    if (lsu_gnt_s) begin
      sel_wr_s    = bus.lsu_wr;
      sel_addr_s  = bus.lsu_addr;
      sel_wdata_s = bus.lsu_wdata;
    end else if (dma_gnt_s) begin
      sel_wr_s    = bus.dma_wr;
      sel_addr_s  = bus.dma_addr;
      sel_wdata_s = bus.dma_wdata;
    end else begin
      sel_wr_s    = 1'b0;
      sel_addr_s  = {AW{1'b0}};
      sel_wdata_s = {DW{1'b0}};
    end
  end

  assign bus.lsu_gnt      = lsu_gnt_s;
  assign bus.dma_gnt      = dma_gnt_s;
  assign bus.dccm_wren    = (lsu_gnt_s | dma_gnt_s) & sel_wr_s;
  assign bus.dccm_rden    = (lsu_gnt_s | dma_gnt_s) & ~sel_wr_s;
  assign bus.dccm_wr_addr = sel_addr_s;
  assign bus.dccm_rd_addr = sel_addr_s;
  assign bus.dccm_wr_data = sel_wdata_s;

  // A read issued just before reset must not surface while reset is held.
  assign bus.lsu_rvalid   = lsu_rd_r & ~rst;
  assign bus.dma_rvalid   = dma_rd_r & ~rst;
  assign bus.rd_data      = (bus.lsu_rvalid | bus.dma_rvalid) ? bus.dccm_rd_data : {DW{1'b0}};

endmodule

// File: tb/tb_dccm_port_arb.sv
// -----------------------------------------------------------------------------
// tb_dccm_port_arb
// Purpose : self-checking bench for dccm_port_arb. A behavioural DCCM sits on
//           the memory pins; expected read returns are queued when a read
//           grant is expected and popped when an rvalid appears.
// -----------------------------------------------------------------------------
module tb_dccm_port_arb;
  localparam int AW = 16;
  localparam int DW = 39;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dccm_port_arb_if #(.AW(AW), .DW(DW)) bus ();

  dccm_port_arb #(.AW(AW), .DW(DW), .DMA_MAX_STALL(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            owner;   // 1 = LSU, 2 = DMA
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] dccm_mem[int];
  logic [DW-1:0] ref_mem[int];
  int            total = 0;
  int            bad   = 0;
  int            cyc_n = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    return {7'h2a, 16'hbeef, a16};
  endfunction

  // Behavioural DCCM: 1-cycle read latency, junk on rd_data when not reading.
  always @(posedge clk) begin
    if (bus.dccm_rden) begin
      if (dccm_mem.exists(int'(bus.dccm_rd_addr))) begin
        bus.dccm_rd_data <= dccm_mem[int'(bus.dccm_rd_addr)];
      end else begin
        bus.dccm_rd_data <= init_word(int'(bus.dccm_rd_addr));
      end
    end else begin
      bus.dccm_rd_data <= {7'h55, 32'hdead_c0de};
    end
    if (bus.dccm_wren) begin
      dccm_mem[int'(bus.dccm_wr_addr)] = bus.dccm_wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic set_lsu(input logic req, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    bus.lsu_req   = req;
    bus.lsu_wr    = wr;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    bus.dma_req   = req;
    bus.dma_wr    = wr;
    bus.dma_addr  = addr;
    bus.dma_wdata = wd;
  endtask

  // One cycle: check grants/pins against the expected owner, retire or
  // expect read returns, queue new expected returns, advance to next negedge.
  task automatic cyc(input logic e_lg, input logic e_dg);
    logic          e_any;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
    logic          lv;
    logic          dv;
    exp_t          e;
    #1;
    e_any  = e_lg | e_dg;
    e_wr   = e_lg ? bus.lsu_wr    : bus.dma_wr;
    e_addr = e_lg ? bus.lsu_addr  : bus.dma_addr;
    e_wd   = e_lg ? bus.lsu_wdata : bus.dma_wdata;
    check_val("lsu_gnt", 64'(bus.lsu_gnt), 64'(e_lg));
    check_val("dma_gnt", 64'(bus.dma_gnt), 64'(e_dg));
    check_val("dccm_wren", 64'(bus.dccm_wren), 64'(e_any & e_wr));
    check_val("dccm_rden", 64'(bus.dccm_rden), 64'(e_any & ~e_wr));
    check_val("dccm_wr_addr", 64'(bus.dccm_wr_addr), e_any ? 64'(e_addr) : 64'd0);
    check_val("dccm_rd_addr", 64'(bus.dccm_rd_addr), e_any ? 64'(e_addr) : 64'd0);
    check_val("dccm_wr_data", 64'(bus.dccm_wr_data), e_any ? 64'(e_wd) : 64'd0);

    if (rst) begin
      sb_q.delete();
    end
    lv = bus.lsu_rvalid;
    dv = bus.dma_rvalid;
    if (lv || dv) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_rvalid", 64'({lv, dv}), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("rv_owner", 64'({lv, dv}), (e.owner == 1) ? 64'd2 : 64'd1);
        check_val("rd_data", 64'(bus.rd_data), 64'(e.data));
        check_val("rv_latency", 64'(cyc_n), 64'(e.due));
      end
    end else begin
      check_val("rd_data_idle", 64'(bus.rd_data), 64'd0);
      if (sb_q.size() > 0 && sb_q[0].due <= cyc_n) begin
        e = sb_q.pop_front();
        check_val("rv_missing", 64'({lv, dv}), (e.owner == 1) ? 64'd2 : 64'd1);
      end
    end

    if (!rst && e_any) begin
      if (e_wr) begin
        ref_mem[int'(e_addr)] = e_wd;
      end else begin
        e_rd = ref_mem.exists(int'(e_addr)) ? ref_mem[int'(e_addr)] : init_word(int'(e_addr));
        sb_q.push_back('{owner: (e_lg ? 1 : 2), data: e_rd, due: cyc_n + 1});
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_lsu(1'b0, 1'b0, 16'h0000, 39'h0);
    set_dma(1'b0, 1'b0, 16'h0000, 39'h0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.freeze = 1'b0;
    set_lsu(1'b0, 1'b0, 16'h0000, 39'h0);
    set_dma(1'b0, 1'b0, 16'h0000, 39'h0);
    @(negedge clk);

    // Reset: requests present but nothing may be granted.
    set_lsu(1'b1, 1'b0, 16'h0040, 39'h0);
    set_dma(1'b1, 1'b1, 16'h0044, 39'h1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // Lone LSU read of 0x40.
    set_lsu(1'b1, 1'b0, 16'h0040, 39'h0);
    cyc(1'b1, 1'b0);
    idle(2);

    // Continuous contention: 8 LSU wins, forced DMA in cycle 9, LSU in 10.
    set_lsu(1'b1, 1'b0, 16'h0010, 39'h0);
    set_dma(1'b1, 1'b0, 16'h0020, 39'h0);
    for (int k = 1; k <= 10; k++) cyc(k != 9, k == 9);
    idle(2);

    // Freeze for 3 cycles mid-stall: counter holds at 3.
    set_lsu(1'b1, 1'b0, 16'h0011, 39'h0);
    set_dma(1'b1, 1'b0, 16'h0021, 39'h0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    bus.freeze = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    bus.freeze = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    idle(2);

    // DMA write 0x1234 to 0x80, then LSU reads it back next cycle.
    set_dma(1'b1, 1'b1, 16'h0080, 39'h1234);
    cyc(1'b0, 1'b1);
    set_dma(1'b0, 1'b0, 16'h0000, 39'h0);
    set_lsu(1'b1, 1'b0, 16'h0080, 39'h0);
    cyc(1'b1, 1'b0);
    idle(2);

    // DMA read granted, then reset: no rvalid may appear.
    set_dma(1'b1, 1'b0, 16'h0090, 39'h0);
    cyc(1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // Reset at stall_cnt=7 restarts the count: 8 fresh lost cycles needed.
    set_lsu(1'b1, 1'b0, 16'h0012, 39'h0);
    set_dma(1'b1, 1'b0, 16'h0022, 39'h0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    idle(2);

    // DMA drops its request at stall_cnt=5: counter restarts from 0.
    set_lsu(1'b1, 1'b0, 16'h0013, 39'h0);
    set_dma(1'b1, 1'b0, 16'h0023, 39'h0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    bus.dma_req = 1'b0;
    cyc(1'b1, 1'b0);
    bus.dma_req = 1'b1;
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);

    // Mixed: LSU write, DMA write, alternating reads back to back.
    set_lsu(1'b1, 1'b1, 16'h0100, 39'h7f_0000_0abc);
    set_dma(1'b0, 1'b0, 16'h0000, 39'h0);
    cyc(1'b1, 1'b0);
    set_lsu(1'b0, 1'b0, 16'h0000, 39'h0);
    set_dma(1'b1, 1'b1, 16'h0104, 39'h00_5a5a_5a5a);
    cyc(1'b0, 1'b1);
    set_dma(1'b0, 1'b0, 16'h0000, 39'h0);
    set_lsu(1'b1, 1'b0, 16'h0104, 39'h0);
    cyc(1'b1, 1'b0);
    set_lsu(1'b0, 1'b0, 16'h0000, 39'h0);
    set_dma(1'b1, 1'b0, 16'h0100, 39'h0);
    cyc(1'b0, 1'b1);
    idle(3);

    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
